mul_float_seq: RTL and testbench

MUL_FLOAT_SEQ -- requirements
Module: mul_float_seq

---
 rtl/float_pkg.sv | 22 ++
 rtl/mul_float_seq_mant.sv | 47 ++++
 rtl/mul_float_seq.sv | 140 ++++++++++++++
 tb/tb_mul_float_seq.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Shared IEEE-754 single-precision constants, field widths and FSM states
// for the sequential float arithmetic units (mul_float, div_float).
package float_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 24;
  localparam int PROD_W = 48;

  localparam int EXP_BIAS = 127;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    NORM,
    DONE
  } state_t;

endpackage

// File: rtl/mul_float_seq_mant.sv
// Iterative shift-and-add 24x24 mantissa multiplier; retires BPC
// multiplier bits per step, LSB first, into a 48-bit accumulator.
module mant_mul_seq
  import float_pkg::*;
#(
  parameter int BPC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [MANT_W-1:0] a,
  input  logic [MANT_W-1:0] b,
  output logic [PROD_W-1:0] prod
);

  logic [PROD_W-1:0] acc, acc_n;
  logic [PROD_W-1:0] mc, mc_n;
  logic [MANT_W-1:0] mp, mp_n;

  always_comb begin
    acc_n = acc;
    for (int i = 0; i < BPC; i++)
      if (mp[i]) acc_n = acc_n + (mc << i);
    mc_n = mc << BPC;
    mp_n = mp >> BPC;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      mc  <= '0;
      mp  <= '0;
    end else if (load) begin
      acc <= '0;
      mc  <= {{(PROD_W-MANT_W){1'b0}}, a};
      mp  <= b;
    end else if (step) begin
      acc <= acc_n;
      mc  <= mc_n;
      mp  <= mp_n;
    end
  end

  assign prod = acc;

endmodule

// File: rtl/mul_float_seq.sv
// Sequential IEEE-754 single multiplier, fixed latency N+2.
// Define MUL_FLOAT_ROUND_EN for round-to-nearest-even; default truncates.
module mul_float_seq
  import float_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] mcand,
  input  logic [31:0] mplier,
  output logic        busy,
  output logic        done,
  output logic [31:0] quo,
  output logic        err
);

  localparam int N = MANT_W / BITS_PER_CYCLE;

  state_t state, state_n;
  logic [4:0]  cnt;
  logic [31:0] a_q, b_q;
  logic        load, step;
  logic [PROD_W-1:0] prod;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = MUL;
      MUL:  if (cnt == 5'(N-1)) state_n = NORM;
      NORM: state_n = DONE;
      DONE: state_n = start ? MUL : IDLE;
    endcase
  end

  always_comb begin
    busy = (state == MUL) || (state == NORM);
    done = (state == DONE);
    load = start && ((state == IDLE) || (state == DONE));
    step = (state == MUL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      a_q <= '0;
      b_q <= '0;
    end else if (load) begin
      cnt <= '0;
      a_q <= mcand;
      b_q <= mplier;
    end else if (step) begin
      cnt <= cnt + 5'd1;
    end
  end

  mant_mul_seq #(.BPC(BITS_PER_CYCLE)) u_mant (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .a    ({1'b1, mcand[FRAC_W-1:0]}),
    .b    ({1'b1, mplier[FRAC_W-1:0]}),
    .prod (prod)
  );

  logic              sgn;
  logic [EXP_W-1:0]  ea, eb;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [9:0]        e;
  logic [FRAC_W-1:0] f;
  logic              rnd;
  logic [MANT_W-1:0] fr;
  logic [31:0]       res;
  logic              res_err;

`ifdef MUL_FLOAT_ROUND_EN
  logic g, s;
`else
  logic unused_lsb;
  assign unused_lsb = ^prod[22:0];
`endif

  always_comb begin
    sgn    = a_q[31] ^ b_q[31];
    ea     = a_q[30:23];
    eb     = b_q[30:23];
    a_nan  = (ea == 8'hFF) && (a_q[22:0] != '0);
    b_nan  = (eb == 8'hFF) && (b_q[22:0] != '0);
    a_inf  = (ea == 8'hFF) && (a_q[22:0] == '0);
    b_inf  = (eb == 8'hFF) && (b_q[22:0] == '0);
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    e = {2'b0, ea} + {2'b0, eb} - 10'(EXP_BIAS)
      + {9'b0, prod[47]};
    f = prod[47] ? prod[46:24] : prod[45:23];
`ifdef MUL_FLOAT_ROUND_EN
    g   = prod[47] ? prod[23] : prod[22];
    s   = prod[47] ? |prod[22:0] : |prod[21:0];
    rnd = g & (s | f[0]);
`else
    rnd = 1'b0;
`endif
    fr = {1'b0, f} + {23'b0, rnd};
    // fraction overflow on rounding bumps the exponent
    if (fr[23]) e = e + 10'd1;
    res     = {sgn, e[7:0], fr[22:0]};
    res_err = 1'b0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      res     = QNAN;
      res_err = 1'b1;
    end else if (a_inf || b_inf) begin
      res = POS_INF | {sgn, 31'b0};
    end else if (a_zero || b_zero) begin
      res = {sgn, 31'b0};
    end else if ($signed(e) >= 10'sd255) begin
      res     = POS_INF | {sgn, 31'b0};
      res_err = 1'b1;
    end else if ($signed(e) <= 10'sd0) begin
      res = {sgn, 31'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo <= '0;
      err <= 1'b0;
    end else if (state == NORM) begin
      quo <= res;
      err <= res_err;
    end
  end

endmodule

// File: tb/tb_mul_float_seq.sv
// Scoreboard bench for mul_float_seq, BITS_PER_CYCLE=1 (done at T+26).
// Expected results are hand-computed; MUL_FLOAT_ROUND_EN selects one vector.
module tb_mul_float_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] mcand = '0;
  logic [31:0] mplier = '0;
  logic        busy, done, err;
  logic [31:0] quo;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  logic [31:0] sb_q[$];
  logic        sb_e[$];
  int          sb_t[$];

  mul_float_seq #(.BITS_PER_CYCLE(1)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mcand  (mcand),
    .mplier (mplier),
    .busy   (busy),
    .done   (done),
    .quo    (quo),
    .err    (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done cyc=%0d quo=%h err=%b", cyc, quo, err);
      end else begin
        logic [31:0] eq;
        logic        ee;
        int          et;
        eq = sb_q.pop_front();
        ee = sb_e.pop_front();
        et = sb_t.pop_front();
        if (quo !== eq || err !== ee || cyc !== et) begin
          failures++;
          $display("FAIL result quo=%h err=%b cyc=%0d required quo=%h err=%b cyc=%0d",
                   quo, err, cyc, eq, ee, et);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Drive a request in the current (negedge) cycle; returns one cycle later.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic ee,
                       input bit expect_done, output int c);
    c      = cyc;
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    if (expect_done) begin
      sb_q.push_back(eq);
      sb_e.push_back(ee);
      sb_t.push_back(c + 26);
    end
    @(negedge clk);
    start  = 1'b0;
    mcand  = $urandom;
    mplier = $urandom;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((sb_q.size() != 0 || busy || done) && k < 200) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 200) begin
      failures++;
      $display("FAIL timeout pending=%0d required=0", sb_q.size());
      sb_q.delete();
      sb_e.delete();
      sb_t.delete();
    end
  endtask

  localparam int NV = 8;
  logic [31:0] va[NV] = '{32'h3FC00000, 32'h80000000, 32'h7F800000,
                          32'h7FC00001, 32'h00800000, 32'h00000001,
                          32'hFF800000, 32'hC0400000};
  logic [31:0] vb[NV] = '{32'h3FC00000, 32'h3F800000, 32'hC0000000,
                          32'h3F800000, 32'h00800000, 32'hBF800000,
                          32'hFF800000, 32'hC0400000};
  logic [31:0] vq[NV] = '{32'h40100000, 32'h80000000, 32'hFF800000,
                          32'h7FC00000, 32'h00000000, 32'h80000000,
                          32'h7F800000, 32'h41100000};
  logic        ve[NV] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    int c;
    bit ok;
    logic [31:0] rq;

    repeat (3) @(negedge clk);
    chk("reset_state", {busy, done, err, quo[28:0]}, 32'h0);
    chk("reset_quo", quo, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    issue(32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b1, c);
    ok = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      if (!busy || done) ok = 1'b0;
      @(negedge clk);
    end
    chk("busy_window", {31'b0, ok}, 32'h1);
    chk("busy_at_done", {31'b0, busy}, 32'h0);
    wait_idle();

    issue(32'h40000000, 32'hC0400000, 32'hC0C00000, 1'b0, 1'b1, c);
    repeat (4) @(negedge clk);
    mcand  = 32'h3F800000;
    mplier = 32'h3F800000;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (30) @(negedge clk);

    issue(32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1, 1'b1, c);
    wait_idle();
    issue(32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b1, 1'b1, c);
    wait_idle();

`ifdef MUL_FLOAT_ROUND_EN
    rq = 32'h40100002;
`else
    rq = 32'h40100001;
`endif
    issue(32'h3FC00001, 32'h3FC00001, rq, 1'b0, 1'b1, c);
    wait_idle();

    for (int i = 0; i < NV; i++) begin
      issue(va[i], vb[i], vq[i], ve[i], 1'b1, c);
      wait_idle();
    end

    issue(32'h3F800000, 32'h40000000, 32'h0, 1'b0, 1'b0, c);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy_done", {30'b0, busy, done}, 32'h0);
    chk("abort_quo", quo, 32'h0);
    @(negedge clk);
    chk("restart_cycle", cyc - c, 32'd12);
    issue(32'h40400000, 32'h40000000, 32'h40C00000, 1'b0, 1'b1, c);
    wait_idle();

    issue(32'h40000000, 32'h40000000, 32'h40800000, 1'b0, 1'b1, c);
    repeat (25) @(negedge clk);
    chk("b2b_done_seen", {31'b0, done}, 32'h1);
    issue(32'h3F000000, 32'h40800000, 32'h40000000, 1'b0, 1'b1, c);
    wait_idle();

    repeat (30) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
